// File: rtl/unpack.sv
// Width-splitting stream stage: one W*D-bit input word leaves as up to D W-bit words,
// least-significant slice first. Define UNPACK_LAST_EN to add the m_last port.
module unpack #(
  parameter  int W  = 8,
  parameter  int D  = 2,
  localparam int IW = $clog2(D)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_stb,
  input  logic [W*D-1:0] s_dat,
  input  logic [IW-1:0]  s_len,
  output logic           s_rdy,
  input  logic           m_rdy,
  output logic           m_stb,
  output logic [W-1:0]   m_dat
`ifdef UNPACK_LAST_EN
  ,
  output logic           m_last
`endif
);

  localparam logic [IW-1:0] LAST_SLICE = IW'(D - 1);

  logic [D-1:0][W-1:0] data_buf;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       end_idx;
  logic                busy;
  logic                at_end;
  logic                accept;

  assign at_end = (idx == end_idx);

  // A new word may load in the same cycle the final slice of the old one leaves,
  // which keeps m_stb high across word boundaries.
  assign s_rdy  = ~busy | (m_rdy & at_end);
  assign accept = s_stb & s_rdy;

  assign m_stb  = busy;
  assign m_dat  = data_buf[idx];
`ifdef UNPACK_LAST_EN
  assign m_last = busy & at_end;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      idx     <= '0;
      end_idx <= '0;
    end else if (accept) begin
      busy    <= 1'b1;
      idx     <= '0;
      end_idx <= (s_len >= LAST_SLICE) ? LAST_SLICE : s_len;
    end else if (busy && m_rdy) begin
      if (at_end) begin
        busy <= 1'b0;
        idx  <= '0;
      end else begin
        idx  <= idx + 1'b1;
      end
    end
  end

  // NOTE: the data buffer is deliberately left out of reset; m_stb gates its
  // contents, so resetting it would only add reset fan-out to a wide register.
  always_ff @(posedge clk) begin
    if (accept) data_buf <= s_dat;
  end

endmodule
